// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered or show-ahead read port and exact registered status.
// Optional sticky overflow/underflow flags are compiled in when FIFO_ERR_FLAG_EN is defined.
module sync_fifo_param #(
  parameter int kuan      = 16,
  parameter int shenbit   = 11,
  parameter int SHOWAHEAD = 0,
  parameter int AFULL_TH  = 2**shenbit - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               sclr,
  input  logic [kuan-1:0]    data,
  input  logic               wrreq,
  input  logic               rdreq,
  output logic [kuan-1:0]    q,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic [shenbit:0]   usedw
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
`endif
);

  localparam int DEPTH = 2**shenbit;
  localparam int CW    = shenbit + 1;

  localparam logic [shenbit:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [shenbit:0]   AFULL_C   = CW'(AFULL_TH);
  localparam logic [shenbit:0]   AEMPTY_C  = CW'(AEMPTY_TH);
  localparam logic [shenbit:0]   CNT_ONE   = CW'(1);
  localparam logic [shenbit:0]   CNT_ZERO  = CW'(0);
  localparam logic [shenbit-1:0] PTR_ONE   = shenbit'(1);
  localparam logic [shenbit-1:0] PTR_ZERO  = shenbit'(0);
  localparam logic [kuan-1:0]    DATA_ZERO = kuan'(0);

  logic [kuan-1:0]    mem_r [DEPTH];

  logic [shenbit-1:0] wr_ptr_r, rd_ptr_r;
  logic [shenbit:0]   usedw_r;
  logic [kuan-1:0]    q_r;
  logic               empty_r, full_r, aempty_r, afull_r;

  logic               wr_en_s, rd_en_s;
  logic [shenbit-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [shenbit:0]   usedw_nxt_s;
  logic [kuan-1:0]    q_nxt_s;

  assign wr_en_s = wrreq & ~full_r  & ~sclr;
  assign rd_en_s = rdreq & ~empty_r & ~sclr;

  // Next-state for pointers, fill count and the read data register.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    usedw_nxt_s  = usedw_r;
    q_nxt_s      = q_r;
    if (sclr) begin
      wr_ptr_nxt_s = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
      usedw_nxt_s  = CNT_ZERO;
      q_nxt_s      = q_r;
    end else begin
      if (wr_en_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   usedw_nxt_s = usedw_r + CNT_ONE;
        2'b01:   usedw_nxt_s = usedw_r - CNT_ONE;
        default: usedw_nxt_s = usedw_r;
      endcase
      // Show-ahead preloads the next oldest word; a write landing in that slot is bypassed.
      if (SHOWAHEAD != 0) begin
        if (usedw_nxt_s != CNT_ZERO) begin
          if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            q_nxt_s = data;
          end else begin
            q_nxt_s = mem_r[rd_ptr_nxt_s];
          end
        end else begin
          q_nxt_s = q_r;
        end
      end else begin
        if (rd_en_s) begin
          q_nxt_s = mem_r[rd_ptr_r];
        end else begin
          q_nxt_s = q_r;
        end
      end
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Control state and status flags, all derived from the post-edge fill count.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      usedw_r  <= CNT_ZERO;
      q_r      <= DATA_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      aempty_r <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      usedw_r  <= usedw_nxt_s;
      q_r      <= q_nxt_s;
      empty_r  <= (usedw_nxt_s == CNT_ZERO);
      full_r   <= (usedw_nxt_s == DEPTH_C);
      aempty_r <= (usedw_nxt_s <= AEMPTY_C);
      afull_r  <= (usedw_nxt_s >= AFULL_C);
    end
  end

  assign q            = q_r;
  assign usedw        = usedw_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = aempty_r;
  assign almost_full  = afull_r;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_r, udf_r;

  // Sticky error flags; a new rejection outranks clr_err in the same cycle.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (sclr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (wrreq && full_r) begin
        ovf_r <= 1'b1;
      end else if (clr_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (rdreq && empty_r) begin
        udf_r <= 1'b1;
      end else if (clr_err) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

  assign overflow  = ovf_r;
  assign underflow = udf_r;
`endif

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter kuan, 16, data width in bits (1..64).
REQ-002 Parameter shenbit, 11, address width; depth = 2**shenbit entries (2..12).
REQ-003 Parameter SHOWAHEAD, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AFULL_TH, 2**shenbit-2, almost-full threshold (1..2**shenbit).
REQ-005 Parameter AEMPTY_TH, 1, almost-empty threshold (0..2**shenbit-1).
REQ-006 Port clk  in  1  single clock, rising edge.
REQ-007 Port aclr  in  1  asynchronous, active-low reset.
REQ-008 Port sclr  in  1  synchronous flush, active high.
REQ-009 Port data  in  kuan  write data.
REQ-010 Port wrreq  in  1  write request.
REQ-011 Port rdreq  in  1  read request.
REQ-012 Port q  out  kuan  read data.
REQ-013 Port empty, full, almost_empty, almost_full  out  1 each  status flags.
REQ-014 Port usedw  out  shenbit+1  fill count, 0..2**shenbit inclusive.

Function
REQ-015 Write accepted iff wrreq=1 and full=0; data stored at write pointer; write pointer increments modulo 2**shenbit.
REQ-016 Read accepted iff rdreq=1 and empty=0; read pointer increments modulo 2**shenbit.
REQ-017 Rejected requests: no state change; no corruption of memory, pointers or usedw.
REQ-018 Simultaneous accepted write and read: usedw unchanged, both pointers advance.
REQ-019 Full with wrreq=1 and rdreq=1: read accepted, write rejected; usedw decrements by 1.
REQ-020 Empty with wrreq=1 and rdreq=1: write accepted, read rejected; usedw increments by 1.
REQ-021 usedw and all four flags registered; after each edge they reflect every operation accepted at that edge (zero extra lag).
REQ-022 empty=1 iff usedw=0; full=1 iff usedw=2**shenbit (entire depth usable).
REQ-023 almost_full=1 iff usedw>=AFULL_TH; almost_empty=1 iff usedw<=AEMPTY_TH.
REQ-024 SHOWAHEAD=0: q loads oldest entry on the edge accepting a read; q holds otherwise.
REQ-025 SHOWAHEAD=1: q presents oldest entry whenever empty=0, rdreq acts as acknowledge; first write into empty FIFO visible on q with empty=0 one cycle after the write edge.
REQ-026 SHOWAHEAD=1, empty=1: q holds last value presented.
REQ-027 sclr=1 at an edge: pointers and usedw to 0, flags to reset values; wrreq/rdreq that cycle ignored; memory contents and q unchanged.
REQ-028 Pointer wrap-around transparent: continuous streaming over 3x depth preserves order and count.

Reset
REQ-029 aclr=0 asynchronously forces pointers=0, usedw=0, q=0, empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_TH>=1).
REQ-030 Reset mid-operation discards all stored words; first read after release returns first word written after release.
REQ-031 Memory array not reset.

Configuration
REQ-032 Macro FIFO_ERR_FLAG_EN defined: ports overflow (out 1), underflow (out 1), clr_err (in 1) present.
REQ-033 With macro: overflow sets sticky on any rejected write, underflow sets sticky on any rejected read; cleared by aclr=0, sclr=1 or clr_err=1 edge; set wins over clr_err in same cycle.
REQ-034 Macro undefined: the three ports and their logic absent; all other behaviour identical.

Verification (kuan=8, shenbit=4, AFULL_TH=14, AEMPTY_TH=1)
REQ-035 Write 0x01..0x10 -> full=1, usedw=16, almost_full=1 from usedw=14; 17th write ignored, with macro overflow=1.
REQ-036 SHOWAHEAD=0, read 16 -> q=0x01..0x10 each one cycle after read edge, empty=1 after 16th; 17th read gives underflow=1, q stays 0x10.
REQ-037 Full FIFO, wrreq=rdreq=1 one cycle -> usedw=15, q=0x01, full=0.
REQ-038 Stream 48 words with wrreq=rdreq=1 after 8 preloaded -> usedw stays 8, output order intact across pointer wrap.
REQ-039 SHOWAHEAD=1, write 0xA5 into empty -> next cycle empty=0, q=0xA5 before rdreq; rdreq -> empty=1.
REQ-040 Fill 5 words, pulse sclr then aclr low mid-stream -> usedw=0, empty=1, q=0 after aclr; next write/read returns new word.
